// File: rtl/rf_burst_loader.sv
// rtl/rf_burst_loader.sv - burst write sequencer for the 4x8 register file
// Ports: clk, rst_b (sync, active-low); start/base_addr/count burst command;
//        abort; in_data/in_valid/in_ready byte stream; wr_data/wr_addr/wr_e
//        register file write port; busy (LOAD or DONE); done (burst end pulse).
module rf_burst_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_e,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              hs;

  assign in_ready = (state == LOAD) && !abort;
  assign hs       = in_valid && in_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
        end else if (hs && (rem_q == '0)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // busy and done are registered from the next state so they line up with
  // the state register without adding combinational outputs.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      addr_q  <= '0;
      rem_q   <= '0;
      wr_data <= '0;
      wr_addr <= '0;
      wr_e    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_e <= hs;
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        rem_q  <= count;
      end
      if (hs) begin
        wr_data <= in_data;
        wr_addr <= addr_q;
        addr_q  <= addr_q + 1'b1;
        if (rem_q != '0) rem_q <= rem_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_burst_loader.sv
// tb/tb_rf_burst_loader.sv - scoreboard bench for rf_burst_loader
module tb_rf_burst_loader;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start;
  logic [1:0] base_addr;
  logic [1:0] count;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] wr_data;
  logic [1:0] wr_addr;
  logic       wr_e;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // expected write: {done, addr, data}
  logic [10:0] exp_q[$];

  rf_burst_loader #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_data(wr_data), .wr_addr(wr_addr), .wr_e(wr_e),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every wr_e pulse must match the next expected write; done
  // must only appear together with a write.
  always @(negedge clk) begin
    logic [10:0] e;
    if (wr_e) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("write", {21'd0, done, wr_addr, wr_data}, {21'd0, e});
      end
    end else if (done) begin
      chk("done_without_write", {31'd0, done}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] b, input logic [1:0] c);
    start = 1'b1; base_addr = b; count = c;
    step();
    start = 1'b0; base_addr = 2'd0; count = 2'd0;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] a, input logic last);
    in_valid = 1'b1; in_data = d;
    exp_q.push_back({last, a, d});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    step();
    step();
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    logic [7:0] sd [4];
    logic       sv [7];
    int         k;
    rst_b = 1'b0; start = 1'b0; base_addr = 0; count = 0; abort = 0;
    in_data = 0; in_valid = 0;
    step(); step();
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 0);
    chk("reset_wr_e", {31'd0, wr_e}, 0);
    rst_b = 1'b1;
    step();

    // basic burst
    do_start(2'd1, 2'd2);
    chk("basic_in_ready", {31'd0, in_ready}, 1);
    chk("basic_busy", {31'd0, busy}, 1);
    send(8'hAA, 2'd1, 1'b0);
    send(8'hBB, 2'd2, 1'b0);
    send(8'hCC, 2'd3, 1'b1);
    chk("basic_done", {31'd0, done}, 1);
    chk("basic_busy_in_done", {31'd0, busy}, 1);
    chk("basic_ready_in_done", {31'd0, in_ready}, 0);
    step();
    chk("basic_busy_drop", {31'd0, busy}, 0);
    drain("basic");

    // wrap
    do_start(2'd3, 2'd1);
    send(8'h11, 2'd3, 1'b0);
    send(8'h22, 2'd0, 1'b1);
    drain("wrap");

    // stalls: valid pattern 1,0,0,1,1,0,1
    sd[0] = 8'hA0; sd[1] = 8'hA1; sd[2] = 8'hA2; sd[3] = 8'hA3;
    sv[0] = 1; sv[1] = 0; sv[2] = 0; sv[3] = 1; sv[4] = 1; sv[5] = 0; sv[6] = 1;
    do_start(2'd2, 2'd3);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (sv[i]) begin
        send(sd[k], 2'd2 + k[1:0], (k == 3));
        k++;
      end else begin
        in_valid = 1'b0; in_data = 8'hEE;
        step();
      end
    end
    drain("stall");

    // abort
    do_start(2'd0, 2'd3);
    send(8'h01, 2'd0, 1'b0);
    send(8'h02, 2'd1, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle", {31'd0, busy}, 0);
    chk("abort_no_done", {31'd0, done}, 0);
    step();
    do_start(2'd0, 2'd0);
    send(8'h77, 2'd0, 1'b1);
    drain("after_abort");

    // start while busy: during LOAD and during DONE
    do_start(2'd1, 2'd3);
    send(8'hD0, 2'd1, 1'b0);
    start = 1'b1; base_addr = 2'd3; count = 2'd0;
    send(8'hD1, 2'd2, 1'b0);
    start = 1'b0;
    send(8'hD2, 2'd3, 1'b0);
    send(8'hD3, 2'd0, 1'b1);
    start = 1'b1; base_addr = 2'd2; count = 2'd1;
    step();
    start = 1'b0;
    chk("busy_start_ignored", {31'd0, busy}, 0);
    drain("busy_start");

    // reset mid-LOAD with start held
    do_start(2'd1, 2'd3);
    send(8'h3C, 2'd1, 1'b0);
    step();
    rst_b = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h99; base_addr = 2'd2;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_wr_e", {31'd0, wr_e}, 0);
    chk("rst_wr_addr", {30'd0, wr_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst_b = 1'b1; start = 1'b0; in_valid = 1'b0;
    drain("reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
